// File: rtl/hazard_md_scheduler_if.sv
// Bundles the hazard/forwarding/MDU control signals between the pipeline datapath and hazard_md_scheduler.
interface hazard_md_scheduler_if;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic       d_is_md;
    logic [4:0] e_rs;
    logic [4:0] e_rt;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic [4:0] w_wa;
    logic       md_start;
    logic       md_is_div;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;
    logic       md_busy;
    logic       md_done;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        output e_rs, e_rt, e_wa, e_tnew, m_wa, m_tnew, w_wa,
        output md_start, md_is_div, flush,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, md_done
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        input  e_rs, e_rt, e_wa, e_tnew, m_wa, m_tnew, w_wa,
        input  md_start, md_is_div, flush,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, md_done
    );
endinterface

// File: rtl/hazard_md_scheduler.sv
// Five-stage MIPS hazard unit: forwarding selects, RAW stall, and the mult/div busy sequencer.
module hazard_md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_md_scheduler_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             data_stall;
    logic             md_stall;

    // Register 0 is hardwired to zero, so it can never create a dependency.
    function automatic logic addr_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] sel_d(input logic [4:0] src, input logic [4:0] e_wa,
                                         input logic [1:0] e_tnew, input logic [4:0] m_wa,
                                         input logic [1:0] m_tnew);
        if (addr_hit(src, e_wa) && e_tnew == 2'd0)
            return 2'b01;
        else if (addr_hit(src, m_wa) && m_tnew == 2'd0)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] src, input logic [4:0] m_wa,
                                         input logic [1:0] m_tnew, input logic [4:0] w_wa);
        if (addr_hit(src, m_wa) && m_tnew == 2'd0)
            return 2'b01;
        else if (addr_hit(src, w_wa))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        bus.fwd_d_rs = sel_d(bus.d_rs, bus.e_wa, bus.e_tnew, bus.m_wa, bus.m_tnew);
        bus.fwd_d_rt = sel_d(bus.d_rt, bus.e_wa, bus.e_tnew, bus.m_wa, bus.m_tnew);
        bus.fwd_e_rs = sel_e(bus.e_rs, bus.m_wa, bus.m_tnew, bus.w_wa);
        bus.fwd_e_rt = sel_e(bus.e_rt, bus.m_wa, bus.m_tnew, bus.w_wa);
    end

    // A stall is needed only when the producer's result arrives later than the consumer needs it.
    always_comb begin
        data_stall = (addr_hit(bus.d_rs, bus.e_wa) && (bus.d_tuse_rs < bus.e_tnew))
                  || (addr_hit(bus.d_rs, bus.m_wa) && (bus.d_tuse_rs < bus.m_tnew))
                  || (addr_hit(bus.d_rt, bus.e_wa) && (bus.d_tuse_rt < bus.e_tnew))
                  || (addr_hit(bus.d_rt, bus.m_wa) && (bus.d_tuse_rt < bus.m_tnew));
        md_stall   = bus.d_is_md && (bus.md_start || (state == BUSY));
        bus.stall  = data_stall || md_stall;
    end

    // DONE accepts a new issue so back-to-back mult/div lose no cycle; BUSY always runs to completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.md_start && !bus.flush) begin
                        state <= BUSY;
                        count <= bus.md_is_div ? DIV_LOAD : MULT_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (count == '0)
                        state <= DONE;
                    else
                        count <= count - CNT_ONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.md_busy = (state == BUSY);
    assign bus.md_done = (state == DONE);

endmodule
